// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int MAX_REQ = 8;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_e;

  // Index reached by stepping 'step' places after 'base', wrapping modulo n.
  function automatic int rr_index(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first asserted request found when
// searching from rr_ptr_i+1 upward, wrapping modulo NUM_REQ.
module uart_rr_pick
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               any_req_o
);

  // Walk the search order backwards so the closest requester is written last.
  always_comb begin
    int idx;
    idx       = 0;
    winner_o  = '0;
    any_req_o = |req_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = rr_index(int'(rr_ptr_i), k, NUM_REQ);
      if (req_i[idx]) begin
        winner_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing the UART TX datapath among NUM_REQ byte
// requesters. A grant is held until the transmitter reports tx_done.
// Optional burst continuation is enabled with the UART_SCHED_BURST_EN macro.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_MAX = 16,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      uart_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_ready,
  input  logic                      tx_done,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy
);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] pick_id;
  logic           any_req;
  logic           gnt_valid;
  logic           release_grant;

`ifdef UART_SCHED_BURST_EN
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       last_q, last_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_last, 8'(BURST_MAX)};
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (pick_id),
    .any_req_o (any_req)
  );

  assign gnt_valid = req_valid[grant_q];
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

  // Next-state, grant bookkeeping and handshake muxing.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    release_grant = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    req_ready     = '0;
`ifdef UART_SCHED_BURST_EN
    burst_cnt_d   = burst_cnt_q;
    last_d        = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (uart_en && any_req) begin
          grant_d = pick_id;
          state_d = SEND;
        end
      end

      SEND: begin
        tx_valid = gnt_valid;
        tx_data  = req_data[int'(grant_q)*BYTE_W +: BYTE_W];
        if (!gnt_valid) begin
          // Requester withdrew before the transmitter took the byte.
          release_grant = 1'b1;
        end else if (tx_ready) begin
          req_ready[grant_q] = 1'b1;
          state_d            = WAIT_DONE;
`ifdef UART_SCHED_BURST_EN
          burst_cnt_d        = burst_cnt_q + 8'd1;
          last_d             = req_last[grant_q];
`endif
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
`ifdef UART_SCHED_BURST_EN
          if (!last_q && (burst_cnt_q < BURST_LIM) && gnt_valid && uart_en) begin
            state_d = SEND;
          end else begin
            release_grant = 1'b1;
          end
`else
          release_grant = 1'b1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Releasing makes the current holder the lowest priority next time.
    if (release_grant) begin
      rr_ptr_d = grant_q;
      state_d  = IDLE;
`ifdef UART_SCHED_BURST_EN
      burst_cnt_d = 8'd0;
`endif
    end
  end

  // Control registers; reset leaves requester 0 first in line.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef UART_SCHED_BURST_EN
  // Burst length and end-of-packet flag of the last accepted byte.
  always_ff @(posedge pclk) begin
    if (preset) begin
      burst_cnt_q <= 8'd0;
      last_q      <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed scenarios followed by
// randomized packet phases checked against a transaction-level model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int BM = 3;

  logic           pclk = 1'b0;
  logic           preset, uart_en, tx_ready, tx_done;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*8-1:0] req_data;
  logic           tx_valid, busy;
  logic [7:0]     tx_data;
  logic [1:0]     grant_id;

  always #5 pclk = ~pclk;

  uart_tx_scheduler #(.NUM_REQ(N), .BURST_MAX(BM)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .uart_en   (uart_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [8:0] dq[N][$];   // bytes still held by each requester {last, data}
  logic [8:0] mq[N][$];   // model copy of the same bytes
  int         m_rr;
  bit         mon_on    = 1'b0;
  bit         auto_mode = 1'b0;
  bit         hs_flag   = 1'b0;
  int         hs_idx    = 0;
  int         done_cnt  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic smp();
    @(negedge pclk);
  endtask

  // Monitor: every accepted byte must match the next expected transfer.
  always @(negedge pclk) begin
    if (mon_on) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h grant=%0d required=none", tx_data, grant_id);
        end else begin
          mon_e = sb.pop_front();
          chk("hs_grant", 32'(grant_id), 32'(mon_e.id));
          chk("hs_data", 32'(tx_data), 32'(mon_e.data));
          chk("hs_ready", 32'(req_ready), 32'(1 << mon_e.id));
        end
        hs_flag = 1'b1;
        hs_idx  = int'(grant_id);
      end else begin
        chk("ready_idle", 32'(req_ready), 32'd0);
      end
    end
  end

  // Autonomous requesters and transmitter used in the random phases.
  always @(posedge pclk) begin
    if (auto_mode) begin
      #1;
      if (hs_flag) begin
        hs_flag = 1'b0;
        if (dq[hs_idx].size() > 0) void'(dq[hs_idx].pop_front());
        done_cnt = int'($urandom_range(0, 3));
      end
      if (done_cnt == 0) begin
        tx_done  = 1'b1;
        done_cnt = -1;
      end else begin
        tx_done = (done_cnt < 0) && ($urandom_range(0, 7) == 0);
        if (done_cnt > 0) done_cnt--;
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (dq[i].size() > 0);
        req_data[i*8 +: 8] = (dq[i].size() > 0) ? dq[i][0][7:0] : 8'($urandom);
        req_last[i] = (dq[i].size() > 0) ? dq[i][0][8] : 1'b0;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      uart_en  = 1'b1;
    end
  end

  // Reference: serve requesters in round-robin order at transaction level.
  task automatic run_model();
    int  g, cnt;
    bit  cont;
    logic [8:0] b;
    forever begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      end
      if (g < 0) break;
      cnt = 0;
      do begin
        b = mq[g].pop_front();
        sb.push_back('{id: g, data: b[7:0]});
        cnt++;
`ifdef UART_SCHED_BURST_EN
        cont = !b[8] && (cnt < BM) && (mq[g].size() > 0);
`else
        cont = 1'b0;
`endif
      end while (cont);
      m_rr = g;
    end
  endtask

  task automatic load(input int p);
    int         n;
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (p == 0)      n = 2;
      else if (p == 1) n = (i == 1) ? 5 : ((i == 3) ? 2 : 0);
      else             n = int'($urandom_range(0, 5));
      for (int j = 0; j < n; j++) begin
        if (p < 2) b = {1'b0, 4'(i), 4'(j)};
        else       b = {($urandom_range(0, 2) == 0), 8'($urandom)};
        dq[i].push_back(b);
        mq[i].push_back(b);
      end
    end
  endtask

  task automatic run_phase(input int p);
    bit drained;
    load(p);
    run_model();
    smp();
    hs_flag   = 1'b0;
    done_cnt  = -1;
    auto_mode = 1'b1;
    drained   = 1'b0;
    for (int c = 0; c < 4000 && !drained; c++) begin
      smp();
      drained = (sb.size() == 0) && (busy === 1'b0) && (done_cnt < 0);
      for (int i = 0; i < N; i++) if (dq[i].size() > 0) drained = 1'b0;
    end
    chk("phase_drain", 32'(sb.size()), 32'd0);
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout phase=%0d actual=busy required=idle", p);
    end
    auto_mode = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      mq[i].delete();
    end
    step();
    req_valid = '0;
    tx_ready  = 1'b0;
    tx_done   = 1'b0;
  endtask

  initial begin
    preset = 1'b1; uart_en = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tx_ready = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    mon_on = 1'b1;
    smp();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Lone requester 2 with one byte.
    step(); req_valid = 4'b0100; req_data[23:16] = 8'hA5; uart_en = 1'b1;
    smp(); chk("lat_before", 32'(tx_valid), 32'd0);
    smp();
    chk("lat_tx_valid", 32'(tx_valid), 32'd1);
    chk("lat_tx_data", 32'(tx_data), 32'hA5);
    chk("lat_grant", 32'(grant_id), 32'd2);
    chk("lat_busy", 32'(busy), 32'd1);
    step(); tx_ready = 1'b1; sb.push_back('{id: 2, data: 8'hA5});
    smp(); chk("ready_pass", 32'(req_ready), 32'b0100);
    step(); req_valid = '0; tx_ready = 1'b0;
    smp();
    chk("wait_tx_valid", 32'(tx_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    step(); tx_done = 1'b1;
    step(); tx_done = 1'b0;
    smp(); chk("done_busy", 32'(busy), 32'd0);

    // Reset while offering a byte.
    step(); req_valid = 4'b1001; req_data[7:0] = 8'h11; req_data[31:24] = 8'h33;
    step(); smp();
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    chk("pre_rst_grant", 32'(grant_id), 32'd3);
    step(); preset = 1'b1;
    step(); preset = 1'b0;
    smp();
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step(); smp();
    chk("post_rst_valid", 32'(tx_valid), 32'd1);
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_data", 32'(tx_data), 32'h11);
    step(); req_valid = '0;
    step(); smp(); chk("withdraw_busy", 32'(busy), 32'd0);

    // Enable cleared while waiting for the frame to finish.
    step(); req_valid = 4'b0011; req_data[7:0] = 8'hC0; req_data[15:8] = 8'hC1;
    step(); smp();
    chk("en_grant", 32'(grant_id), 32'd1);
    chk("en_valid", 32'(tx_valid), 32'd1);
    step(); tx_ready = 1'b1; sb.push_back('{id: 1, data: 8'hC1});
    step(); tx_ready = 1'b0; uart_en = 1'b0; tx_done = 1'b1;
    step(); tx_done = 1'b0;
    smp(); chk("dis_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("dis_tx_valid", 32'(tx_valid), 32'd0);
      chk("dis_idle", 32'(busy), 32'd0);
    end
    step(); uart_en = 1'b1;
    step(); smp();
    chk("resume_valid", 32'(tx_valid), 32'd1);
    chk("resume_grant", 32'(grant_id), 32'd0);
    step(); req_valid = '0;
    step(); smp(); chk("resume_release", 32'(busy), 32'd0);
    chk("directed_sb", 32'(sb.size()), 32'd0);

    // Fresh start for the model-checked phases.
    step(); preset = 1'b1;
    step(); preset = 1'b0;
    m_rr = N - 1;
    for (int p = 0; p < 10; p++) run_phase(p);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
